// File: rtl/ceespu_intc.sv
// ceespu_intc: eight-source prioritised interrupt controller feeding the ceespu core's I_int/I_int_vector.
// Build option CEESPU_INTC_EDGE_EN adds the TRIG register and per-source rising-edge pending latches.
module ceespu_intc #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [7:0]  I_irq,
    output logic        O_int,
    output logic [2:0]  O_int_vector,
    input  logic        I_int_ack,
    input  logic [15:0] I_addr,
    input  logic        I_en,
    input  logic [3:0]  I_we,
    input  logic [31:0] I_wdata,
    output logic [31:0] O_rdata,
    output logic        O_sel
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_CTRL = 3'd2;
    localparam logic [2:0] OFF_TRIG = 3'd3;
    localparam logic [2:0] OFF_EOI  = 3'd4;

    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  sirq;
    logic [7:0]  pend_q;
    logic [7:0]  pend_d;
    logic [7:0]  mask_q;
    logic [7:0]  trig;
    logic        gie_q;
    state_t      state_q;
    state_t      state_d;
    logic [2:0]  vec_q;
    logic [2:0]  vec_d;
    logic [2:0]  lowest;
    logic [7:0]  req;
    logic        hit;
    logic        wr;
    logic        rd;
    logic [2:0]  off;
    logic        ack_take;
    logic        eoi_wr;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign unused_bits = ^{I_we[3:1], I_wdata[31:8], I_addr[1:0]};

    // Bus decode: the 32-byte window is matched on address bits 15:5.
    assign hit = (I_addr[15:5] == BASE_ADDR[15:5]);
    assign off = I_addr[4:2];
    assign wr  = I_en & I_we[0] & hit;
    assign rd  = I_en & (I_we == 4'd0) & hit;

    assign eoi_wr = wr && (off == OFF_EOI);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= I_irq;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sirq = sync_q[SYNC_STAGES-1];

`ifdef CEESPU_INTC_EDGE_EN
    logic [7:0] sirq_d;
    logic [7:0] trig_q;
    logic [7:0] rise;
    logic [7:0] clr;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            sirq_d <= '0;
            trig_q <= '0;
        end else begin
            sirq_d <= sirq;
            if (wr && (off == OFF_TRIG)) trig_q <= I_wdata[7:0];
        end
    end

    assign rise = sirq & ~sirq_d;
    assign trig = trig_q;
    assign clr  = ((wr && (off == OFF_PEND)) ? I_wdata[7:0] : 8'd0)
                | (ack_take ? (8'd1 << vec_q) : 8'd0);
    // Level bits mirror the synchroniser; edge bits latch, with a new edge beating any clear.
    assign pend_d = (sirq & ~trig) | (((pend_q & ~clr) | rise) & trig);
`else
    logic unused_ack;

    assign unused_ack = ack_take;
    assign trig       = 8'd0;
    assign pend_d     = sirq;
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pend_q <= '0;
            mask_q <= '0;
            gie_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (wr && (off == OFF_MASK)) mask_q <= I_wdata[7:0];
            if (wr && (off == OFF_CTRL)) gie_q  <= I_wdata[0];
        end
    end

    assign req = pend_q & mask_q & {8{gie_q}};

    always_comb begin
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) lowest = 3'(i);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    // VEC is only reloaded from IDLE, so the presented vector is frozen through REQ/SERVICE.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 8'd0) begin
                    vec_d   = lowest;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (I_int_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_int        = (state_q == ST_REQ);
    assign O_int_vector = vec_q;

    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_PEND: rd_val = {24'd0, pend_q};
            OFF_MASK: rd_val = {24'd0, mask_q};
            OFF_CTRL: rd_val = {26'd0, state_q == ST_REQ, vec_q, state_q == ST_SERVICE, gie_q};
            OFF_TRIG: rd_val = {24'd0, trig};
            default:  rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_rdata <= '0;
            O_sel   <= 1'b0;
        end else begin
            O_sel <= I_en & hit;
            if (rd) O_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_ceespu_intc.sv
// Self-checking bench for ceespu_intc: directed scenarios plus randomized mask/source patterns
// checked against a rule-level model (lowest masked index wins, fixed 4-cycle request latency).
module tb_ceespu_intc;

    localparam logic [15:0] A_PEND = 16'hFF00;
    localparam logic [15:0] A_MASK = 16'hFF04;
    localparam logic [15:0] A_CTRL = 16'hFF08;
    localparam logic [15:0] A_TRIG = 16'hFF0C;
    localparam logic [15:0] A_EOI  = 16'hFF10;
    localparam logic [15:0] A_RSVD = 16'hFF14;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        o_int;
    logic [2:0]  vec;
    logic        ack;
    logic [15:0] addr;
    logic        en;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;

    int          n_tests;
    int          n_fail;
    logic [2:0]  last_vec;

    ceespu_intc dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_irq        (irq),
        .O_int        (o_int),
        .O_int_vector (vec),
        .I_int_ack    (ack),
        .I_addr       (addr),
        .I_en         (en),
        .I_we         (we),
        .I_wdata      (wdata),
        .O_rdata      (rdata),
        .O_sel        (sel)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model helper: priority is the lowest set index, -1 when nothing requests.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 4'hF;
        en    = 1'b1;
        tick();
        en    = 1'b0;
        we    = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        addr = a;
        we   = 4'h0;
        en   = 1'b1;
        tick();
        en   = 1'b0;
        d    = rdata;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        logic [31:0] d;
        irq = 8'hFF;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        last_vec = 3'd0;
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %0h expected 0", o_int); end
        n_tests++; if (vec !== 3'd0) begin n_fail++; $display("FAIL reset_vec: got %0h expected 0", vec); end
        n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0h expected 0", sel); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", rdata); end
        repeat (3) tick();
        bus_read(A_PEND, d);
        n_tests++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_pend: got %0h expected ff", d); end
        bus_read(A_MASK, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mask: got %0h expected 0", d); end
        bus_read(A_CTRL, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", d); end
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL reset_masked_int: got %0h expected 0", o_int); end
        irq = 8'h00;
        repeat (4) tick();
    endtask

    task automatic test_bus();
        logic [31:0] d;
        bus_write(A_MASK, 32'h0000_005A);
        n_tests++; if (sel !== 1'b1) begin n_fail++; $display("FAIL bus_sel_write: got %0h expected 1", sel); end
        bus_read(A_MASK, d);
        n_tests++; if (d !== 32'h5A) begin n_fail++; $display("FAIL bus_mask_rw: got %0h expected 5a", d); end
        n_tests++; if (sel !== 1'b1) begin n_fail++; $display("FAIL bus_sel_read: got %0h expected 1", sel); end
        bus_read(16'hFE04, d);
        n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL bus_sel_outside: got %0h expected 0", sel); end
        n_tests++; if (d !== 32'h5A) begin n_fail++; $display("FAIL bus_rdata_hold: got %0h expected 5a", d); end
        bus_write(16'hFF24, 32'h0);
        n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL bus_sel_alias: got %0h expected 0", sel); end
        addr = A_MASK; wdata = 32'h0000_FF00; we = 4'b0010; en = 1'b1;
        tick();
        en = 1'b0; we = 4'h0;
        bus_read(A_MASK, d);
        n_tests++; if (d !== 32'h5A) begin n_fail++; $display("FAIL bus_outside_and_lane: got %0h expected 5a", d); end
        bus_read(A_RSVD, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL bus_reserved: got %0h expected 0", d); end
        bus_read(A_EOI, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL bus_eoi_read: got %0h expected 0", d); end
        bus_write(A_TRIG, 32'hFF);
        bus_read(A_TRIG, d);
`ifdef CEESPU_INTC_EDGE_EN
        n_tests++; if (d !== 32'hFF) begin n_fail++; $display("FAIL bus_trig: got %0h expected ff", d); end
`else
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_trig: got %0h expected 0", d); end
`endif
        bus_write(A_TRIG, 32'h0);
        pulse_ack();
        bus_read(A_CTRL, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL bus_ack_idle: got %0h expected 0", d); end
    endtask

    task automatic test_priority();
        bus_write(A_MASK, 32'h24);
        bus_write(A_CTRL, 32'h1);
        irq = 8'h24;
        repeat (3) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL prio_early: got %0h expected 0", o_int); end
        tick();
        n_tests++; if (o_int !== 1'b1) begin n_fail++; $display("FAIL prio_latency: got %0h expected 1", o_int); end
        n_tests++; if (vec !== 3'd2) begin n_fail++; $display("FAIL prio_vec2: got %0h expected 2", vec); end
        pulse_ack();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL prio_ack_drop: got %0h expected 0", o_int); end
        irq = 8'h20;
        repeat (4) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL prio_service_hold: got %0h expected 0", o_int); end
        bus_write(A_EOI, 32'h0);
        tick();
        n_tests++; if (o_int !== 1'b1) begin n_fail++; $display("FAIL prio_second_int: got %0h expected 1", o_int); end
        n_tests++; if (vec !== 3'd5) begin n_fail++; $display("FAIL prio_vec5: got %0h expected 5", vec); end
        last_vec = 3'd5;
        pulse_ack();
        irq = 8'h00;
        repeat (4) tick();
        bus_write(A_EOI, 32'h0);
        repeat (2) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL prio_quiet: got %0h expected 0", o_int); end
    endtask

    task automatic test_eoi_gating();
        int bad;
        bus_write(A_MASK, 32'h01);
        irq = 8'h01;
        repeat (4) tick();
        n_tests++; if (o_int !== 1'b1 || vec !== 3'd0) begin n_fail++; $display("FAIL eoi_req: got int=%0h vec=%0h expected int=1 vec=0", o_int, vec); end
        pulse_ack();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_int !== 1'b0) bad++;
            if (i == 4) pulse_ack();
            else tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL eoi_gate: got %0d high cycles expected 0", bad); end
        bus_write(A_EOI, 32'h0);
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL eoi_same_cycle: got %0h expected 0", o_int); end
        tick();
        n_tests++; if (o_int !== 1'b1) begin n_fail++; $display("FAIL eoi_rise: got %0h expected 1", o_int); end
        last_vec = 3'd0;
        pulse_ack();
        irq = 8'h00;
        repeat (4) tick();
        bus_write(A_EOI, 32'h0);
        repeat (2) tick();
    endtask

    task automatic test_frozen();
        bus_write(A_MASK, 32'h08);
        irq = 8'h08;
        repeat (4) tick();
        n_tests++; if (o_int !== 1'b1 || vec !== 3'd3) begin n_fail++; $display("FAIL frozen_req: got int=%0h vec=%0h expected int=1 vec=3", o_int, vec); end
        bus_write(A_MASK, 32'h00);
        irq = 8'h00;
        repeat (5) tick();
        n_tests++; if (o_int !== 1'b1 || vec !== 3'd3) begin n_fail++; $display("FAIL frozen_hold: got int=%0h vec=%0h expected int=1 vec=3", o_int, vec); end
        last_vec = 3'd3;
        pulse_ack();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL frozen_ack: got %0h expected 0", o_int); end
        bus_write(A_EOI, 32'h0);
        repeat (2) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL frozen_quiet: got %0h expected 0", o_int); end
    endtask

`ifdef CEESPU_INTC_EDGE_EN
    task automatic test_edge();
        logic [31:0] d;
        bus_write(A_TRIG, 32'h01);
        bus_write(A_MASK, 32'h01);
        bus_write(A_CTRL, 32'h1);
        irq = 8'h01;
        repeat (3) tick();
        irq = 8'h00;
        tick();
        n_tests++; if (o_int !== 1'b1 || vec !== 3'd0) begin n_fail++; $display("FAIL edge_req: got int=%0h vec=%0h expected int=1 vec=0", o_int, vec); end
        repeat (4) tick();
        bus_read(A_PEND, d);
        n_tests++; if (d !== 32'h01) begin n_fail++; $display("FAIL edge_latched: got %0h expected 1", d); end
        pulse_ack();
        bus_read(A_PEND, d);
        n_tests++; if (d !== 32'h00) begin n_fail++; $display("FAIL edge_ack_clear: got %0h expected 0", d); end
        bus_read(A_CTRL, d);
        n_tests++; if (d !== 32'h03) begin n_fail++; $display("FAIL edge_ctrl: got %0h expected 3", d); end
        last_vec = 3'd0;
        bus_write(A_EOI, 32'h0);
        repeat (2) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL edge_no_repeat: got %0h expected 0", o_int); end
    endtask

    task automatic test_simul();
        logic [31:0] d;
        bus_write(A_MASK, 32'h00);
        bus_write(A_TRIG, 32'h02);
        irq = 8'h02;
        repeat (2) tick();
        bus_write(A_PEND, 32'h02);
        bus_read(A_PEND, d);
        n_tests++; if (d !== 32'h02) begin n_fail++; $display("FAIL simul_set_wins: got %0h expected 2", d); end
        bus_write(A_PEND, 32'h02);
        bus_read(A_PEND, d);
        n_tests++; if (d !== 32'h00) begin n_fail++; $display("FAIL simul_w1c: got %0h expected 0", d); end
        irq = 8'h00;
        bus_write(A_TRIG, 32'h00);
        repeat (4) tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] d;
        for (int it = 0; it < 24; it++) begin
            logic [7:0]  m;
            logic [7:0]  s;
            logic [7:0]  hits;
            logic        g;
            int          low;
            logic [31:0] exp_ctrl;
            m    = 8'($urandom_range(0, 255));
            s    = 8'($urandom_range(1, 255));
            g    = ($urandom_range(0, 3) != 0);
            hits = g ? (m & s) : 8'h00;
            low  = lowest(hits);
            bus_write(A_MASK, {24'd0, m});
            bus_write(A_CTRL, {31'd0, g});
            irq = s;
            repeat (4) tick();
            n_tests++; if (o_int !== (hits != 8'h00)) begin n_fail++; $display("FAIL rand_int[%0d]: got %0h expected %0h", it, o_int, hits != 8'h00); end
            if (hits != 8'h00) begin
                n_tests++; if (vec !== 3'(low)) begin n_fail++; $display("FAIL rand_vec[%0d]: got %0h expected %0h", it, vec, low); end
                last_vec = 3'(low);
            end
            bus_read(A_PEND, d);
            n_tests++; if (d !== {24'd0, s}) begin n_fail++; $display("FAIL rand_pend[%0d]: got %0h expected %0h", it, d, s); end
            exp_ctrl = {26'd0, hits != 8'h00, last_vec, 1'b0, g};
            bus_read(A_CTRL, d);
            n_tests++; if (d !== exp_ctrl) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %0h expected %0h", it, d, exp_ctrl); end
            if (hits != 8'h00) begin
                pulse_ack();
                exp_ctrl = {26'd0, 1'b0, last_vec, 1'b1, g};
                bus_read(A_CTRL, d);
                n_tests++; if (d !== exp_ctrl) begin n_fail++; $display("FAIL rand_service[%0d]: got %0h expected %0h", it, d, exp_ctrl); end
                irq = 8'h00;
                repeat (4) tick();
                bus_write(A_EOI, 32'h0);
                repeat (2) tick();
                n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d]: got %0h expected 0", it, o_int); end
            end else begin
                irq = 8'h00;
                repeat (4) tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(A_MASK, 32'h10);
        bus_write(A_CTRL, 32'h1);
        irq = 8'h10;
        repeat (4) tick();
        n_tests++; if (o_int !== 1'b1 || vec !== 3'd4) begin n_fail++; $display("FAIL rstmid_req: got int=%0h vec=%0h expected int=1 vec=4", o_int, vec); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_vec = 3'd0;
        n_tests++; if (o_int !== 1'b0 || vec !== 3'd0) begin n_fail++; $display("FAIL rstmid_drop: got int=%0h vec=%0h expected int=0 vec=0", o_int, vec); end
        bus_read(A_MASK, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_mask: got %0h expected 0", d); end
        bus_read(A_CTRL, d);
        n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_ctrl: got %0h expected 0", d); end
        repeat (4) tick();
        n_tests++; if (o_int !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got %0h expected 0", o_int); end
        irq = 8'h00;
    endtask

    // Sequence and final report
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_vec = 3'd0;
        rst      = 1'b1;
        irq      = 8'h00;
        ack      = 1'b0;
        addr     = 16'h0000;
        en       = 1'b0;
        we       = 4'h0;
        wdata    = 32'h0;
        test_reset();
        test_bus();
        test_priority();
        test_eoi_gating();
        test_frozen();
`ifdef CEESPU_INTC_EDGE_EN
        test_edge();
        test_simul();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
